magia_l2_banked_mem: RTL and testbench

MAGIA_L2_BANKED_MEM -- requirements
Module: magia_l2_banked_mem

---
 rtl/magia_l2_banked_mem.sv | 198 +++++++++++++++++++
 tb/tb_magia_l2_banked_mem.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/magia_l2_banked_mem.sv
// Multi-port, word-interleaved banked L2 memory.
// Each bank has its own round-robin arbiter and serves at most one request per cycle.
// Out-of-range requests are granted at once and answered with an error.
// Every response appears a fixed RdLatency cycles after its grant.
module magia_l2_banked_mem #(
   parameter int unsigned          NumPorts     = 4,
   parameter int unsigned          NumBanks     = 4,
   parameter int unsigned          WordsPerBank = 1024,
   parameter int unsigned          DataWidth    = 32,
   parameter int unsigned          AddrWidth    = 32,
   parameter int unsigned          RdLatency    = 1,
   parameter logic [AddrWidth-1:0] BaseAddr     = '0
) (
   input  logic                                   clk_i,
   input  logic                                   rst_ni,
   input  logic [NumPorts-1:0]                    req_i,
   output logic [NumPorts-1:0]                    gnt_o,
   input  logic [NumPorts-1:0][AddrWidth-1:0]     addr_i,
   input  logic [NumPorts-1:0]                    we_i,
   input  logic [NumPorts-1:0][DataWidth/8-1:0]   be_i,
   input  logic [NumPorts-1:0][DataWidth-1:0]     wdata_i,
   output logic [NumPorts-1:0]                    rvalid_o,
   output logic [NumPorts-1:0][DataWidth-1:0]     rdata_o,
   output logic [NumPorts-1:0]                    err_o
);

   localparam int unsigned     BeWidth    = DataWidth / 8;
   localparam int unsigned     OffBits    = $clog2(BeWidth);
   localparam int unsigned     BankW      = (NumBanks > 1) ? $clog2(NumBanks) : 1;
   localparam int unsigned     RowW       = (WordsPerBank > 1) ? $clog2(WordsPerBank) : 1;
   localparam int unsigned     PortW      = (NumPorts > 1) ? $clog2(NumPorts) : 1;
   localparam longint unsigned TotalWords = longint'(NumBanks) * longint'(WordsPerBank);

   // Pick the first candidate at or after the priority pointer, wrapping around.
   function automatic logic [PortW-1:0] rr_pick(input logic [NumPorts-1:0] cand,
                                                input logic [PortW-1:0]    ptr);
      logic [PortW-1:0] win;
      logic [PortW-1:0] idx;
      logic             found;
      win   = '0;
      found = 1'b0;
      for (int i = 0; i < NumPorts; i++) begin
         idx = PortW'((int'(ptr) + i) % NumPorts);
         if (!found && cand[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
      return win;
   endfunction

   logic [AddrWidth-1:0] word_idx [NumPorts];
   logic [NumPorts-1:0]  oor;
   logic [BankW-1:0]     bank_sel [NumPorts];
   logic [RowW-1:0]      row_sel  [NumPorts];

   // Decode each port's byte address into bank, row and an out-of-range flag.
   always_comb begin
      for (int p = 0; p < NumPorts; p++) begin
         word_idx[p] = (addr_i[p] - BaseAddr) >> OffBits;
         oor[p]      = (addr_i[p] < BaseAddr) || (64'(word_idx[p]) >= 64'(TotalWords));
         bank_sel[p] = BankW'(word_idx[p] % NumBanks);
         row_sel[p]  = RowW'(word_idx[p] / NumBanks);
      end
   end

   logic [NumPorts-1:0] cand     [NumBanks];
   logic [NumBanks-1:0] bank_act;
   logic [PortW-1:0]    bank_win [NumBanks];
   logic [PortW-1:0]    ptr_q    [NumBanks];
   logic [PortW-1:0]    ptr_d    [NumBanks];

   // Per-bank arbitration among in-range requesters and the next priority pointer.
   always_comb begin
      // NOTE: every combinational output gets a default before any condition, so no latch is inferred.
      bank_act = '0;
      for (int b = 0; b < NumBanks; b++) begin
         cand[b]     = '0;
         bank_win[b] = '0;
         ptr_d[b]    = ptr_q[b];
         for (int p = 0; p < NumPorts; p++) begin
            cand[b][p] = rst_ni && req_i[p] && !oor[p] && (bank_sel[p] == BankW'(b));
         end
         bank_act[b] = |cand[b];
         bank_win[b] = rr_pick(cand[b], ptr_q[b]);
         if (bank_act[b]) begin
            ptr_d[b] = (bank_win[b] == PortW'(NumPorts - 1)) ? '0 : bank_win[b] + 1'b1;
         end
      end
   end

   // A port is granted when out of range or when it won its bank.
   always_comb begin
      gnt_o = '0;
      for (int p = 0; p < NumPorts; p++) begin
         gnt_o[p] = rst_ni && req_i[p] &&
                    (oor[p] || (bank_act[bank_sel[p]] && (bank_win[bank_sel[p]] == PortW'(p))));
      end
   end

   // Round-robin pointers; all return to port 0 on reset.
   always_ff @(posedge clk_i) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!rst_ni) begin
         for (int b = 0; b < NumBanks; b++) ptr_q[b] <= '0;
      end else begin
         for (int b = 0; b < NumBanks; b++) ptr_q[b] <= ptr_d[b];
      end
   end

   logic [DataWidth-1:0] bank_rdata [NumBanks];

   for (genvar b = 0; b < NumBanks; b++) begin : g_bank
      logic [DataWidth-1:0] mem_q [WordsPerBank];
      logic [DataWidth-1:0] rdata_q;
      logic [PortW-1:0]     win;
      assign win = bank_win[b];

      // Byte-masked write or synchronous read for the winning port of this bank.
      always_ff @(posedge clk_i) begin
         // NOTE: storage and its read register are not reset; contents must survive reset and read data is qualified by the response pipeline.
         if (bank_act[b]) begin
            if (we_i[win]) begin
               for (int j = 0; j < BeWidth; j++) begin
                  if (be_i[win][j]) mem_q[row_sel[win]][8*j +: 8] <= wdata_i[win][8*j +: 8];
               end
            end else begin
               rdata_q <= mem_q[row_sel[win]];
            end
         end
      end

      assign bank_rdata[b] = rdata_q;
   end

   logic [NumPorts-1:0]                s0_vld_q, s0_err_q, s0_rd_q;
   logic [BankW-1:0]                   s0_bank_q [NumPorts];
   logic [NumPorts-1:0][DataWidth-1:0] s0_data;

   // First response stage: records what each grant must return.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         s0_vld_q <= '0;
         s0_err_q <= '0;
         s0_rd_q  <= '0;
         for (int p = 0; p < NumPorts; p++) s0_bank_q[p] <= '0;
      end else begin
         s0_vld_q <= gnt_o;
         s0_err_q <= gnt_o & oor;
         s0_rd_q  <= gnt_o & ~oor & ~we_i;
         for (int p = 0; p < NumPorts; p++) s0_bank_q[p] <= bank_sel[p];
      end
   end

   // Steer bank read data to the requesting port; zero for writes and errors.
   always_comb begin
      s0_data = '0;
      for (int p = 0; p < NumPorts; p++) begin
         if (s0_rd_q[p]) s0_data[p] = bank_rdata[s0_bank_q[p]];
      end
   end

   if (RdLatency == 1) begin : g_lat1
      assign rvalid_o = s0_vld_q;
      assign err_o    = s0_err_q;
      assign rdata_o  = s0_data;
   end else begin : g_latn
      localparam int unsigned Depth = RdLatency - 1;
      logic [NumPorts-1:0]                dl_vld_q  [Depth];
      logic [NumPorts-1:0]                dl_err_q  [Depth];
      logic [NumPorts-1:0][DataWidth-1:0] dl_data_q [Depth];

      // Delay line carrying responses through the remaining latency stages.
      always_ff @(posedge clk_i) begin
         if (!rst_ni) begin
            for (int k = 0; k < Depth; k++) begin
               dl_vld_q[k]  <= '0;
               dl_err_q[k]  <= '0;
               dl_data_q[k] <= '0;
            end
         end else begin
            dl_vld_q[0]  <= s0_vld_q;
            dl_err_q[0]  <= s0_err_q;
            dl_data_q[0] <= s0_data;
            for (int k = 1; k < Depth; k++) begin
               dl_vld_q[k]  <= dl_vld_q[k-1];
               dl_err_q[k]  <= dl_err_q[k-1];
               dl_data_q[k] <= dl_data_q[k-1];
            end
         end
      end

      assign rvalid_o = dl_vld_q[Depth-1];
      assign err_o    = dl_err_q[Depth-1];
      assign rdata_o  = dl_data_q[Depth-1];
   end

endmodule

// File: tb/tb_magia_l2_banked_mem.sv
// Directed bench for magia_l2_banked_mem.
// Instance A: defaults with RdLatency=2.
// Instance B: RdLatency=3, BaseAddr=0x100, used for the mid-flight reset case.
module tb_magia_l2_banked_mem;

   localparam int NP = 4;
   localparam int DW = 32;
   localparam int AW = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a, rst_b;

   logic [NP-1:0]            a_req, a_gnt, a_we, a_rvalid, a_err;
   logic [NP-1:0][AW-1:0]    a_addr;
   logic [NP-1:0][DW/8-1:0]  a_be;
   logic [NP-1:0][DW-1:0]    a_wdata, a_rdata;

   logic [NP-1:0]            b_req, b_gnt, b_we, b_rvalid, b_err;
   logic [NP-1:0][AW-1:0]    b_addr;
   logic [NP-1:0][DW/8-1:0]  b_be;
   logic [NP-1:0][DW-1:0]    b_wdata, b_rdata;

   int n_vec = 0;
   int n_err = 0;

   magia_l2_banked_mem #(.RdLatency(2)) u_dut_a (
      .clk_i(clk), .rst_ni(rst_a),
      .req_i(a_req), .gnt_o(a_gnt), .addr_i(a_addr), .we_i(a_we), .be_i(a_be),
      .wdata_i(a_wdata), .rvalid_o(a_rvalid), .rdata_o(a_rdata), .err_o(a_err)
   );

   magia_l2_banked_mem #(.RdLatency(3), .BaseAddr(32'h0000_0100)) u_dut_b (
      .clk_i(clk), .rst_ni(rst_b),
      .req_i(b_req), .gnt_o(b_gnt), .addr_i(b_addr), .we_i(b_we), .be_i(b_be),
      .wdata_i(b_wdata), .rvalid_o(b_rvalid), .rdata_o(b_rdata), .err_o(b_err)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic nxt();
      @(negedge clk);
   endtask

   task automatic a_idle();
      a_req = '0; a_we = '0; a_addr = '0; a_be = '0; a_wdata = '0;
   endtask

   task automatic b_idle();
      b_req = '0; b_we = '0; b_addr = '0; b_be = '0; b_wdata = '0;
   endtask

   task automatic a_port(input int p, input logic we, input logic [AW-1:0] addr,
                         input logic [DW/8-1:0] be, input logic [DW-1:0] wd);
      a_req[p] = 1'b1; a_we[p] = we; a_addr[p] = addr; a_be[p] = be; a_wdata[p] = wd;
   endtask

   task automatic b_port(input int p, input logic we, input logic [AW-1:0] addr,
                         input logic [DW/8-1:0] be, input logic [DW-1:0] wd);
      b_req[p] = 1'b1; b_we[p] = we; b_addr[p] = addr; b_be[p] = be; b_wdata[p] = wd;
   endtask

   initial begin
      rst_a = 1'b0;
      rst_b = 1'b0;
      a_idle();
      b_idle();

      // Reset: requests are never granted while reset is low.
      nxt(); a_port(0, 1'b0, 32'h0, 4'hF, 32'h0); #1;
      check("a_gnt_in_reset", a_gnt, 0);
      nxt(); a_idle();
      nxt(); rst_a = 1'b1; #1;
      check("a_rvalid_after_reset", a_rvalid, 0);
      check("a_err_after_reset", a_err, 0);
      check("a_rdata_after_reset", 64'(|a_rdata), 0);

      // Four ports contend for bank 0: grants rotate 0,1,2,3, responses follow two cycles later.
      for (int c = 0; c < 7; c++) begin
         nxt();
         if (c == 0) begin
            a_port(0, 1'b0, 32'h00, 4'hF, 32'h0);
            a_port(1, 1'b0, 32'h10, 4'hF, 32'h0);
            a_port(2, 1'b0, 32'h20, 4'hF, 32'h0);
            a_port(3, 1'b0, 32'h30, 4'hF, 32'h0);
         end
         if (c == 4) a_idle();
         #1;
         check($sformatf("rr_gnt_c%0d", c), a_gnt, (c < 4) ? (4'b0001 << c) : 4'b0000);
         check($sformatf("rr_rvalid_c%0d", c), a_rvalid,
               (c >= 2 && c < 6) ? (4'b0001 << (c - 2)) : 4'b0000);
      end

      // Full write then read-back on port 0.
      nxt(); a_port(0, 1'b1, 32'h0, 4'hF, 32'hDEAD_BEEF); #1;
      check("wr_gnt", a_gnt, 4'b0001);
      nxt(); a_idle(); a_port(0, 1'b0, 32'h0, 4'hF, 32'h0); #1;
      check("rd_gnt", a_gnt, 4'b0001);
      check("rd_rvalid_early", a_rvalid, 0);
      nxt(); a_idle(); #1;
      check("wr_rvalid", a_rvalid, 4'b0001);
      check("wr_rdata_zero", a_rdata[0], 0);
      check("wr_err", a_err, 0);
      nxt(); #1;
      check("rd_rvalid", a_rvalid, 4'b0001);
      check("rd_rdata", a_rdata[0], 32'hDEAD_BEEF);
      check("rd_err", a_err, 0);
      nxt(); #1;
      check("rd_rvalid_one_wide", a_rvalid, 0);
      check("idle_rdata_zero", 64'(|a_rdata), 0);

      // Different banks in the same cycle: both granted, both answer together.
      nxt(); a_idle(); a_port(1, 1'b1, 32'h4, 4'hF, 32'hCAFE_F00D); #1;
      check("b1_wr_gnt", a_gnt, 4'b0010);
      nxt(); a_idle(); a_port(0, 1'b0, 32'h0, 4'hF, 32'h0); a_port(1, 1'b0, 32'h4, 4'hF, 32'h0); #1;
      check("dual_gnt", a_gnt, 4'b0011);
      nxt(); a_idle(); #1;
      check("b1_wr_rvalid", a_rvalid, 4'b0010);
      check("b1_wr_rdata", a_rdata[1], 0);
      nxt(); #1;
      check("dual_rvalid", a_rvalid, 4'b0011);
      check("dual_rdata0", a_rdata[0], 32'hDEAD_BEEF);
      check("dual_rdata1", a_rdata[1], 32'hCAFE_F00D);
      check("dual_err", a_err, 0);

      // Partial write over an existing word.
      nxt(); a_idle(); a_port(2, 1'b1, 32'h8, 4'hF, 32'h1122_3344); #1;
      check("pw_full_gnt", a_gnt, 4'b0100);
      nxt(); a_idle(); a_port(2, 1'b1, 32'h8, 4'b0010, 32'h0000_AB00); #1;
      check("pw_part_gnt", a_gnt, 4'b0100);
      nxt(); a_idle(); a_port(2, 1'b0, 32'h8, 4'hF, 32'h0); #1;
      check("pw_rd_gnt", a_gnt, 4'b0100);
      nxt(); a_idle();
      nxt(); #1;
      check("pw_rvalid", a_rvalid, 4'b0100);
      check("pw_rdata", a_rdata[2], 32'h1122_AB44);

      // Out of range (0x4000) next to bank-0 and last-word (0x3FFC) requests.
      nxt(); a_idle();
      a_port(3, 1'b0, 32'h4000, 4'hF, 32'h0);
      a_port(0, 1'b0, 32'h0000, 4'hF, 32'h0);
      a_port(1, 1'b0, 32'h3FFC, 4'hF, 32'h0); #1;
      check("oor_gnt", a_gnt, 4'b1011);
      nxt(); a_idle(); a_port(3, 1'b1, 32'h4000, 4'hF, 32'h5555_5555); #1;
      check("oor_wr_gnt", a_gnt, 4'b1000);
      nxt(); a_idle(); a_port(0, 1'b0, 32'h0, 4'hF, 32'h0); #1;
      check("oor_rvalid", a_rvalid, 4'b1011);
      check("oor_err", a_err, 4'b1000);
      check("oor_rdata", a_rdata[3], 0);
      check("oor_peer_rdata", a_rdata[0], 32'hDEAD_BEEF);
      nxt(); a_idle(); #1;
      check("oor_wr_rvalid", a_rvalid, 4'b1000);
      check("oor_wr_err", a_err, 4'b1000);
      check("oor_wr_rdata", a_rdata[3], 0);
      nxt(); #1;
      check("no_alias_rvalid", a_rvalid, 4'b0001);
      check("no_alias_rdata", a_rdata[0], 32'hDEAD_BEEF);
      check("no_alias_err", a_err, 0);

      // Instance B: below-base error, then reset one cycle after a read grant.
      nxt(); rst_b = 1'b1; b_port(0, 1'b1, 32'h100, 4'hF, 32'h1234_5678); #1;
      check("b_wr_gnt", b_gnt, 4'b0001);
      nxt(); b_idle(); b_port(2, 1'b0, 32'hFC, 4'hF, 32'h0); #1;
      check("b_below_gnt", b_gnt, 4'b0100);
      nxt(); b_idle(); #1;
      check("b_rvalid_pending", b_rvalid, 0);
      nxt(); b_port(1, 1'b0, 32'h100, 4'hF, 32'h0); #1;
      check("b_rd_gnt", b_gnt, 4'b0010);
      check("b_wr_rvalid", b_rvalid, 4'b0001);
      check("b_wr_err", b_err, 0);
      nxt(); b_idle(); rst_b = 1'b0; b_port(0, 1'b0, 32'h100, 4'hF, 32'h0); #1;
      check("b_gnt_in_reset", b_gnt, 0);
      check("b_below_rvalid", b_rvalid, 4'b0100);
      check("b_below_err", b_err, 4'b0100);
      check("b_below_rdata", b_rdata[2], 0);
      nxt(); rst_b = 1'b1; b_idle(); #1;
      check("b_post_rst_rvalid0", b_rvalid, 0);
      check("b_post_rst_err0", b_err, 0);
      check("b_post_rst_rdata0", 64'(|b_rdata), 0);
      nxt(); #1;
      check("b_dropped_rvalid", b_rvalid, 0);
      nxt(); b_port(1, 1'b0, 32'h100, 4'hF, 32'h0); b_port(2, 1'b0, 32'h110, 4'hF, 32'h0); #1;
      check("b_ptr_reset_gnt", b_gnt, 4'b0010);
      check("b_post_rst_rvalid2", b_rvalid, 0);
      nxt(); b_idle(); #1;
      check("b_post_rst_rvalid3", b_rvalid, 0);
      nxt(); #1;
      check("b_post_rst_rvalid4", b_rvalid, 0);
      nxt(); #1;
      check("b_keep_rvalid", b_rvalid, 4'b0010);
      check("b_keep_rdata", b_rdata[1], 32'h1234_5678);
      check("b_keep_err", b_err, 0);
      nxt(); #1;
      check("b_keep_one_wide", b_rvalid, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
